// File: rtl/idu_pre_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idu_pre_queue_if                                                |
// | Brief    : Fetch-side push bus and issue-side head offer of idu_pre_queue. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface idu_pre_queue_if #(
   parameter int DEPTH = 16
);
   localparam int PTR_W = $clog2(DEPTH);

   logic             flush;
   logic [1:0]       in_valid;
   logic [31:0]      in_pc0;
   logic [31:0]      in_pc1;
   logic [31:0]      in_inst0;
   logic [31:0]      in_inst1;
   logic             in_ready;
   logic             issue_ready;
   logic [1:0]       out_valid;
   logic [31:0]      out_pc0;
   logic [31:0]      out_pc1;
   logic [31:0]      out_inst0;
   logic [31:0]      out_inst1;
   logic             out_w_reg_ena0;
   logic             out_w_reg_ena1;
   logic [4:0]       out_w_reg_dst0;
   logic [4:0]       out_w_reg_dst1;
   logic             out_is_branch0;
   logic             out_is_branch1;
   logic             out_is_jump0;
   logic             out_is_jump1;
   logic             out_is_ls0;
   logic             out_is_ls1;
   logic             out_is_hilo0;
   logic             out_is_hilo1;
   logic [PTR_W:0]   count;

   modport master (
      output flush, in_valid, in_pc0, in_pc1, in_inst0, in_inst1, issue_ready,
      input  in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
      input  out_w_reg_ena0, out_w_reg_ena1, out_w_reg_dst0, out_w_reg_dst1,
      input  out_is_branch0, out_is_branch1, out_is_jump0, out_is_jump1,
      input  out_is_ls0, out_is_ls1, out_is_hilo0, out_is_hilo1, count
   );

   modport slave (
      input  flush, in_valid, in_pc0, in_pc1, in_inst0, in_inst1, issue_ready,
      output in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
      output out_w_reg_ena0, out_w_reg_ena1, out_w_reg_dst0, out_w_reg_dst1,
      output out_is_branch0, out_is_branch1, out_is_jump0, out_is_jump1,
      output out_is_ls0, out_is_ls1, out_is_hilo0, out_is_hilo1, count
   );
endinterface

`default_nettype wire

// File: rtl/idu_pre_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : idu_pre_queue                                                   |
// | Brief    : Pre-decoding circular instruction queue between fetch and       |
// |            issue; offers up to two head entries with a pairing decision.   |
// |            Define IDU_DUAL_ISSUE_EN to enable dual-issue pairing.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module idu_pre_queue #(
   parameter int DEPTH = 16
) (
   input  wire logic      clk,
   input  wire logic      rst,
   idu_pre_queue_if.slave q
);
   localparam int             PTR_W        = $clog2(DEPTH);
   localparam logic [PTR_W:0] c_PUSH_LIMIT = (PTR_W+1)'(DEPTH - 2);
   localparam logic [PTR_W:0] c_ONE        = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] c_TWO        = (PTR_W+1)'(2);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        w_reg_ena;
      logic [4:0]  dst;
      logic        is_branch;
      logic        is_jump;
      logic        is_ls;
      logic        is_hilo;
   } entry_t;

   // Stage-1 MIPS32 decode. Every non-writing class leaves dst at 0, so the
   // write enable reduces to dst != 0; linking branches (BGEZAL/BLTZAL) write $31.
   function automatic entry_t f_predecode(input logic [31:0] pc, input logic [31:0] inst);
      entry_t     e;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      op     = inst[31:26];
      rs     = inst[25:21];
      rt     = inst[20:16];
      rd     = inst[15:11];
      fn     = inst[5:0];
      e      = '0;
      e.pc   = pc;
      e.inst = inst;
      case (op)
         6'h00: begin
            case (fn)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2a, 6'h2b: e.dst = rd;
               6'h08: e.is_jump = 1'b1;
               6'h09: begin
                  e.dst     = rd;
                  e.is_jump = 1'b1;
               end
               6'h10, 6'h12: begin
                  e.dst     = rd;
                  e.is_hilo = 1'b1;
               end
               6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: e.is_hilo = 1'b1;
               default: ;
            endcase
         end
         6'h01: begin
            e.is_branch = 1'b1;
            if (rt[4:1] == 4'b1000) e.dst = 5'd31;
         end
         6'h02: e.is_jump = 1'b1;
         6'h03: begin
            e.is_jump = 1'b1;
            e.dst     = 5'd31;
         end
         6'h04, 6'h05, 6'h06, 6'h07: e.is_branch = 1'b1;
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: e.dst = rt;
         6'h10: if (rs == 5'd0) e.dst = rt;
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
            e.dst   = rt;
            e.is_ls = 1'b1;
         end
         6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: e.is_ls = 1'b1;
         default: ;
      endcase
      e.w_reg_ena = (e.dst != 5'd0);
      return e;
   endfunction

   entry_t           r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   entry_t           w_dec0;
   entry_t           w_dec1;
   entry_t           w_head0;
   entry_t           w_head1;
   logic [PTR_W-1:0] w_wr_ptr1;
   logic [PTR_W-1:0] w_rd_ptr1;
   logic             w_in_ready;
   logic             w_push;
   logic [1:0]       w_push_n;
   logic [1:0]       w_pop_n;
   logic             w_v0;
   logic             w_v1;

   assign w_dec0    = f_predecode(q.in_pc0, q.in_inst0);
   assign w_dec1    = f_predecode(q.in_pc1, q.in_inst1);
   assign w_wr_ptr1 = r_wr_ptr + 1'b1;
   assign w_rd_ptr1 = r_rd_ptr + 1'b1;
   assign w_head0   = r_mem[r_rd_ptr];
   assign w_head1   = r_mem[w_rd_ptr1];

   // Slot1 alone (in_valid == 2'b10) never pushes.
   assign w_in_ready = (r_count <= c_PUSH_LIMIT);
   assign w_push     = w_in_ready && q.in_valid[0];
   assign w_push_n   = w_push ? (q.in_valid[1] ? 2'd2 : 2'd1) : 2'd0;
   assign w_pop_n    = q.issue_ready ? ({1'b0, w_v0} + {1'b0, w_v1}) : 2'd0;

`ifdef IDU_DUAL_ISSUE_EN
   logic w_raw;
   logic w_pair_ok;

   assign w_raw     = w_head0.w_reg_ena &&
                      ((w_head0.dst == w_head1.inst[25:21]) ||
                       (w_head0.dst == w_head1.inst[20:16]));
   assign w_pair_ok = !w_raw &&
                      !(w_head0.is_ls   && w_head1.is_ls) &&
                      !(w_head0.is_hilo && w_head1.is_hilo) &&
                      !w_head1.is_branch && !w_head1.is_jump;

   // A lone branch/jump waits until its delay slot is queued behind it.
   always_comb begin
      w_v0 = (r_count != '0);
      if ((w_head0.is_branch || w_head0.is_jump) && (r_count == c_ONE)) w_v0 = 1'b0;
      w_v1 = w_v0 && (r_count >= c_TWO) && w_pair_ok;
   end
`else
   always_comb begin
      w_v0 = (r_count != '0);
      w_v1 = 1'b0;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_n);
         r_count  <= r_count + (PTR_W+1)'(w_push_n) - (PTR_W+1)'(w_pop_n);
      end
   end

   // Storage carries no reset; unoccupied entries are never offered.
   always_ff @(posedge clk) begin
      if (!rst && !q.flush && w_push) begin
         r_mem[r_wr_ptr] <= w_dec0;
         if (q.in_valid[1]) r_mem[w_wr_ptr1] <= w_dec1;
      end
   end

   assign q.in_ready       = w_in_ready;
   assign q.count          = r_count;
   assign q.out_valid      = {w_v1, w_v0};
   assign q.out_pc0        = w_v0 ? w_head0.pc        : 32'd0;
   assign q.out_inst0      = w_v0 ? w_head0.inst      : 32'd0;
   assign q.out_w_reg_ena0 = w_v0 & w_head0.w_reg_ena;
   assign q.out_w_reg_dst0 = w_v0 ? w_head0.dst       : 5'd0;
   assign q.out_is_branch0 = w_v0 & w_head0.is_branch;
   assign q.out_is_jump0   = w_v0 & w_head0.is_jump;
   assign q.out_is_ls0     = w_v0 & w_head0.is_ls;
   assign q.out_is_hilo0   = w_v0 & w_head0.is_hilo;
   assign q.out_pc1        = w_v1 ? w_head1.pc        : 32'd0;
   assign q.out_inst1      = w_v1 ? w_head1.inst      : 32'd0;
   assign q.out_w_reg_ena1 = w_v1 & w_head1.w_reg_ena;
   assign q.out_w_reg_dst1 = w_v1 ? w_head1.dst       : 5'd0;
   assign q.out_is_branch1 = w_v1 & w_head1.is_branch;
   assign q.out_is_jump1   = w_v1 & w_head1.is_jump;
   assign q.out_is_ls1     = w_v1 & w_head1.is_ls;
   assign q.out_is_hilo1   = w_v1 & w_head1.is_hilo;
endmodule

`default_nettype wire

// File: tb/tb_idu_pre_queue.sv
`default_nettype none
// Self-checking bench for idu_pre_queue: directed plan steps plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_idu_pre_queue;
   localparam int DEPTH = 16;
`ifdef IDU_DUAL_ISSUE_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct packed {
      logic       wen;
      logic [4:0] dst;
      logic       br;
      logic       jmp;
      logic       ls;
      logic       hilo;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          checks = 0;
   int          errors = 0;
   bit          mvalid = 1'b0;
   ent_t        mq[$];
   logic [31:0] pc_ctr = 32'h0040_0000;

   always #5 clk = ~clk;

   idu_pre_queue_if #(.DEPTH(DEPTH)) bus ();
   idu_pre_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));

   function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
      return {6'd0, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Reference decode, written from the instruction-class rules.
   function automatic dec_t mdec(logic [31:0] w);
      dec_t       d;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      op = w[31:26]; rs = w[25:21]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
      d = '0;
      if (op == 6'd0 && (fn inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, [6'd32:6'd39],
                                    6'd42, 6'd43, 6'd9, 6'd16, 6'd18}))
         d.dst = rd;
      else if ((op inside {[6'd8:6'd15], [6'd32:6'd38]}) || (op == 6'd16 && rs == 5'd0))
         d.dst = rt;
      else if (op == 6'd3 || (op == 6'd1 && (rt inside {5'd16, 5'd17})))
         d.dst = 5'd31;
      d.wen  = (d.dst != 5'd0);
      d.br   = op inside {6'd1, [6'd4:6'd7]};
      d.jmp  = (op inside {6'd2, 6'd3}) || (op == 6'd0 && (fn inside {6'd8, 6'd9}));
      d.ls   = op inside {[6'd32:6'd38], 6'd40, 6'd41, 6'd42, 6'd43, 6'd46};
      d.hilo = (op == 6'd0) && (fn inside {[6'd16:6'd19], [6'd24:6'd27]});
      return d;
   endfunction

   function automatic bit pair_ok(logic [31:0] a, logic [31:0] b);
      dec_t da;
      dec_t db;
      da = mdec(a);
      db = mdec(b);
      if (da.wen && (da.dst == b[25:21] || da.dst == b[20:16])) return 1'b0;
      if (da.ls && db.ls) return 1'b0;
      if (da.hilo && db.hilo) return 1'b0;
      if (db.br || db.jmp) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] rinst();
      logic [4:0]  a;
      logic [4:0]  b;
      logic [4:0]  c;
      logic [15:0] imm;
      a   = 5'($urandom_range(0, 7));
      b   = 5'($urandom_range(0, 7));
      c   = 5'($urandom_range(0, 7));
      imm = 16'($urandom());
      case ($urandom_range(0, 17))
         0:       return rtype(a, b, c, 6'h21);
         1:       return {6'd0, 5'd0, b, c, imm[4:0], 6'h00};
         2:       return itype(6'h09, a, b, imm);
         3:       return itype(6'h0f, 5'd0, b, imm);
         4:       return itype(6'h23, a, b, imm);
         5:       return itype(6'h2b, a, b, imm);
         6:       return itype(6'h04, a, b, imm);
         7:       return itype(6'h01, a, 5'd17, imm);
         8:       return {6'h02, 26'($urandom())};
         9:       return {6'h03, 26'($urandom())};
         10:      return rtype(a, 5'd0, 5'd0, 6'h08);
         11:      return rtype(a, 5'd0, c, 6'h09);
         12:      return rtype(a, b, 5'd0, 6'h18);
         13:      return rtype(5'd0, 5'd0, c, 6'h12);
         14:      return {6'h10, 5'd4, b, c, 11'd0};
         15:      return {6'h10, 5'd0, b, c, 11'd0};
         16:      return {6'd0, 20'd0, 6'h0c};
         default: return $urandom();
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(int n, bit v0, bit v1);
      ent_t e0;
      ent_t e1;
      dec_t d0;
      dec_t d1;
      e0 = '{32'd0, 32'd0};
      e1 = '{32'd0, 32'd0};
      d0 = '0;
      d1 = '0;
      if (v0) begin e0 = mq[0]; d0 = mdec(e0.inst); end
      if (v1) begin e1 = mq[1]; d1 = mdec(e1.inst); end
      chk("count", 32'(bus.count), 32'(n));
      chk("in_ready", 32'(bus.in_ready), 32'(DEPTH - n >= 2));
      chk("out_valid", 32'(bus.out_valid), {30'd0, v1, v0});
      chk("pc0", bus.out_pc0, e0.pc);
      chk("inst0", bus.out_inst0, e0.inst);
      chk("pc1", bus.out_pc1, e1.pc);
      chk("inst1", bus.out_inst1, e1.inst);
      chk("dec0", 32'({bus.out_w_reg_ena0, bus.out_w_reg_dst0, bus.out_is_branch0,
                       bus.out_is_jump0, bus.out_is_ls0, bus.out_is_hilo0}), 32'(d0));
      chk("dec1", 32'({bus.out_w_reg_ena1, bus.out_w_reg_dst1, bus.out_is_branch1,
                       bus.out_is_jump1, bus.out_is_ls1, bus.out_is_hilo1}), 32'(d1));
   endtask

   // Inputs already applied; check at mid-cycle, then advance model and DUT.
   task automatic step();
      int   n;
      bit   v0;
      bit   v1;
      bit   push;
      dec_t d;
      #4;
      n  = mq.size();
      v0 = (n >= 1);
      if (DUAL && n == 1) begin
         d = mdec(mq[0].inst);
         if (d.br || d.jmp) v0 = 1'b0;
      end
      v1 = 1'b0;
      if (DUAL && v0 && n >= 2) v1 = pair_ok(mq[0].inst, mq[1].inst);
      if (mvalid) check_all(n, v0, v1);
      push = (DEPTH - n >= 2) && bus.in_valid[0];
      @(posedge clk);
      if (rst || bus.flush) begin
         mq.delete();
         mvalid = 1'b1;
      end else if (mvalid) begin
         if (bus.issue_ready) begin
            if (v0) void'(mq.pop_front());
            if (v1) void'(mq.pop_front());
         end
         if (push) begin
            mq.push_back('{bus.in_pc0, bus.in_inst0});
            if (bus.in_valid[1]) mq.push_back('{bus.in_pc1, bus.in_inst1});
         end
      end
      #1;
   endtask

   task automatic drive(logic [1:0] v, logic [31:0] i0, logic [31:0] i1, logic ir, logic fl);
      bus.in_valid    = v;
      bus.in_pc0      = pc_ctr;
      bus.in_inst0    = i0;
      bus.in_pc1      = pc_ctr + 32'd4;
      bus.in_inst1    = i1;
      bus.issue_ready = ir;
      bus.flush       = fl;
      pc_ctr          = pc_ctr + 32'd8;
      step();
   endtask

   initial begin
      logic [31:0] addu3;
      logic [31:0] addiu5;
      logic [31:0] subu6;
      logic [31:0] beq;
      logic [31:0] alu10;
      logic [31:0] alu11;
      int          accepted;
      int          budget;

      addu3  = rtype(5'd1, 5'd2, 5'd3, 6'h21);
      addiu5 = itype(6'h09, 5'd4, 5'd5, 16'd1);
      subu6  = rtype(5'd3, 5'd4, 5'd6, 6'h23);
      beq    = itype(6'h04, 5'd1, 5'd2, 16'd8);
      alu10  = rtype(5'd1, 5'd2, 5'd10, 6'h21);
      alu11  = rtype(5'd3, 5'd4, 5'd11, 6'h21);

      rst = 1'b1;
      drive(2'b00, 0, 0, 1'b0, 1'b0);
      drive(2'b11, addu3, addiu5, 1'b1, 1'b0);
      rst = 1'b0;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_pc0", bus.out_pc0, 32'd0);

      // ADDU + ADDIU: independent pair
      drive(2'b11, addu3, addiu5, 1'b0, 1'b0);
      chk("p1_out_valid", 32'(bus.out_valid), DUAL ? 32'd3 : 32'd1);
      chk("p1_dst0", 32'(bus.out_w_reg_dst0), 32'd3);
      chk("p1_dst1", 32'(bus.out_w_reg_dst1), DUAL ? 32'd5 : 32'd0);
      chk("p1_count", 32'(bus.count), 32'd2);
      drive(2'b00, 0, 0, 1'b0, 1'b1);

      // RAW on $3 splits the pair
      drive(2'b11, addu3, subu6, 1'b0, 1'b0);
      chk("p2_out_valid", 32'(bus.out_valid), 32'd1);
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      chk("p2_dst0_after_pop", 32'(bus.out_w_reg_dst0), 32'd6);
      chk("p2_count_after_pop", 32'(bus.count), 32'd1);
      drive(2'b00, 0, 0, 1'b1, 1'b0);

      // lone branch then its delay slot
      drive(2'b01, beq, 0, 1'b0, 1'b0);
      chk("p3_lone_branch", 32'(bus.out_valid), DUAL ? 32'd0 : 32'd1);
      drive(2'b01, 32'd0, 0, 1'b0, 1'b0);
      chk("p3_with_slot", 32'(bus.out_valid), DUAL ? 32'd3 : 32'd1);
      drive(2'b00, 0, 0, 1'b0, 1'b1);
      chk("p3_flush_count", 32'(bus.count), 32'd0);

      // fill to DEPTH-1
      for (int i = 0; i < 7; i++) drive(2'b11, 32'd0, 32'd0, 1'b0, 1'b0);
      drive(2'b01, 32'd0, 0, 1'b0, 1'b0);
      chk("p4_count_full", 32'(bus.count), 32'd15);
      chk("p4_in_ready_full", 32'(bus.in_ready), 32'd0);
      drive(2'b11, addu3, addiu5, 1'b0, 1'b0);
      chk("p4_push_ignored", 32'(bus.count), 32'd15);
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      drive(2'b00, 0, 0, 1'b1, 1'b0);
      chk("p4_in_ready_after_pop", 32'(bus.in_ready), 32'd1);
      drive(2'b00, 0, 0, 1'b0, 1'b1);

      // streaming pairs across the pointer wrap
      accepted = 0;
      budget   = 0;
      while (accepted < 40 && budget < 400) begin
         if (bus.in_ready) accepted++;
         drive(2'b11, alu10, alu11, logic'(budget % 2), 1'b0);
         budget++;
      end
      chk("p5_pairs_streamed", 32'(accepted), 32'd40);
      for (int i = 0; i < 20; i++) drive(2'b00, 0, 0, 1'b1, 1'b0);
      chk("p5_drained", 32'(bus.count), 32'd0);

      // flush and reset against simultaneous push and pop
      drive(2'b11, alu10, alu11, 1'b0, 1'b0);
      drive(2'b11, alu10, alu11, 1'b1, 1'b1);
      chk("p6_flush_count", 32'(bus.count), 32'd0);
      chk("p6_flush_valid", 32'(bus.out_valid), 32'd0);
      drive(2'b11, alu10, alu11, 1'b0, 1'b0);
      rst = 1'b1;
      drive(2'b11, alu10, alu11, 1'b1, 1'b0);
      rst = 1'b0;
      chk("p6_rst_count", 32'(bus.count), 32'd0);
      chk("p6_rst_valid", 32'(bus.out_valid), 32'd0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         drive(2'($urandom()), rinst(), rinst(), logic'($urandom_range(0, 2) != 0),
               logic'($urandom_range(0, 59) == 0));
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/idu_pre_queue.md
# idu_pre_queue

Pre-decoding instruction queue between fetch and the decode/issue stage. Accepts up to two fetched instructions per cycle, computes stage-1 decode fields once at write time, and stores them in a parametrised circular buffer. It presents up to two head entries per cycle with a dual-issue pairing decision, so issue logic sees ready-made pairs.

## Interface
- DEPTH, 16, number of entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), pointer width (derived; do not override).

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch mispredict / exception).
- in_valid  in  2  {slot1,slot0} fetch valid; 2'b10 is illegal and treated as 2'b00.
- in_pc0, in_pc1  in  32  fetch PCs.
- in_inst0, in_inst1  in  32  fetch instruction words.
- in_ready  out  1  at least two free entries.
- issue_ready  in  1  downstream accepts what out_valid offers.
- out_valid  out  2  {slot1,slot0}; 2'b10 never driven.
- out_pc0, out_pc1  out  32  head / head+1 PC.
- out_inst0, out_inst1  out  32  head / head+1 instruction.
- out_w_reg_ena0/1  out  1  entry writes a GPR.
- out_w_reg_dst0/1  out  5  destination GPR.
- out_is_branch0/1, out_is_jump0/1, out_is_ls0/1, out_is_hilo0/1  out  1  class flags.
- count  out  PTR_W+1  occupied entries.

## Operation
- Pre-decode (MIPS32), per incoming slot, stored with the entry:
  - dst = rd for SPECIAL ALU/shift/JALR/MFHI/MFLO; rt for ADDI(U)/SLTI(U)/ANDI/ORI/XORI/LUI, loads, MFC0; 31 for JAL/BGEZAL/BLTZAL; else 0.
  - w_reg_ena = 0 for DIV(U)/MULT(U)/JR/MTHI/MTLO/BREAK/SYSCALL/ERET, branches, J, stores, MTC0, or dst==0.
  - is_branch: BEQ/BNE/BGTZ/BLEZ/REGIMM. is_jump: J/JAL/JR/JALR. is_ls: loads/stores. is_hilo: DIV(U)/MULT(U)/MFHI/MFLO/MTHI/MTLO.
- Push: when in_ready & in_valid[0], slot0 written at wr_ptr, slot1 (if valid) at wr_ptr+1; wr_ptr advances by 1 or 2 modulo DEPTH.
- Head offer:
  - out_valid[0] = count≥1, except a branch/jump at head with count==1 is held (waits for its delay slot) — dual-issue builds only.
  - out_valid[1] = out_valid[0] & count≥2 & pair legal.
  - Pair illegal if: slot0 w_reg_ena and dst0 equals rs1 or rt1 (non-zero); both is_ls; both is_hilo; slot1 is_branch or is_jump.
- Pop: on issue_ready, rd_ptr advances by popcount(out_valid).
- count_next = count + pushed − popped; simultaneous push and pop both take effect.
- Outputs of a slot whose out_valid bit is 0 are driven 0.
- flush: overrides push and pop; pointers and count return to 0 next cycle.

## Timing
- Reset (and flush): count=0, pointers=0, out_valid=2'b00, all out_* data 0, in_ready=1.
- Storage fully registered; head outputs combinational from stored entries and count.
- Write-to-offer latency 1 cycle: entry pushed at edge N is visible in out_* after edge N.
- in_ready computed from current count only (DEPTH−count ≥ 2); a same-cycle pop does not raise it.
- Full: count==DEPTH−1 or DEPTH → in_ready=0, pushes ignored.
- Pointer wrap: index DEPTH−1 followed by 0; a pair may straddle the wrap.
- rst in the middle of a push/pop: reset wins; no entry written.

## Configuration
- IDU_DUAL_ISSUE_EN defined: pairing as above, and a lone head branch/jump is held.
- Undefined: out_valid[1] tied 0, no pairing logic, lone head branch/jump offered immediately; at most one pop per cycle. Pre-decode, push and flush behaviour are unchanged.

## Test plan
- Reset, then push ADDU $3,$1,$2 + ADDIU $5,$4,1 → next cycle out_valid=2'b11, w_reg_dst0=3, w_reg_dst1=5, count=2.
- Push ADDU $3,$1,$2 + SUBU $6,$3,$4 (RAW on $3) → out_valid=2'b01; after a pop, SUBU at slot0 with dst0=6.
- Push a lone BEQ → out_valid=2'b00; push its delay-slot NOP → out_valid=2'b11.
- Fill DEPTH=16 to count=15 → in_ready=0, a pushed pair is ignored, count stays 15; pop 2 → in_ready=1.
- Stream 40 pairs with issue_ready toggling → pointers wrap and PC order is preserved; a pair straddling index 15→0 appears in order.
- Assert flush with a simultaneous push and pop → next cycle count=0, out_valid=2'b00; rst behaves identically.
